servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_multi.sv | 130 +++++++++++++
 tb/tb_servo_pwm_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with per-channel hold/sweep positioning.
// Positions are applied only at frame boundaries so each pulse is glitch-free.
module servo_pwm_multi #(
  parameter int CLK_FRE    = 50,
  parameter int CH_NUM     = 4,
  parameter int PERIOD_US  = 20000,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int POS_MAX    = 180,
  parameter int SWEEP_STEP = 1,
  localparam int POS_W     = $clog2(POS_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         mode,
  input  logic                      cmd_valid,
  input  logic [3:0]                cmd_ch,
  input  logic [POS_W-1:0]          cmd_pos,
  output logic                      cmd_ready,
  output logic [CH_NUM-1:0]         pwm_out,
  output logic [CH_NUM*POS_W-1:0]   pos_out,
  output logic                      frame_tick
);

  localparam int unsigned PERIOD_CYC = PERIOD_US * CLK_FRE;
  localparam int unsigned CNT_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned MIN_CYC    = MIN_US * CLK_FRE;
  localparam int unsigned STEP_CYC   = ((MAX_US - MIN_US) * CLK_FRE) / POS_MAX;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [POS_W:0]   POS_MAX_E = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0]   STEP_E    = (POS_W + 1)'(SWEEP_STEP);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [POS_W-1:0]  pos_q [CH_NUM];
  logic [POS_W-1:0]  pos_d [CH_NUM];
  logic [POS_W-1:0]  tgt_q [CH_NUM];
  logic [POS_W-1:0]  tgt_d [CH_NUM];
  logic [CH_NUM-1:0] dir_q, dir_d;  // 1 = sweeping up
  logic [CH_NUM-1:0] pwm_q, pwm_d;

  always_comb begin
    tick  = (cnt_q == LAST_CNT);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  assign cmd_ready  = ~rst;
  assign frame_tick = tick & ~rst;
  assign pwm_out    = pwm_q;

  // Out-of-range channel indices match no entry and are silently dropped.
  always_comb begin
    tgt_d = tgt_q;
    if (cmd_valid && cmd_ready) begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (cmd_ch == 4'(n)) begin
          tgt_d[n] = ({1'b0, cmd_pos} > POS_MAX_E) ? POS_W'(POS_MAX) : cmd_pos;
        end
      end
    end
  end

  always_comb begin
    logic [POS_W:0] cur;
    cur = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      pos_d[n] = pos_q[n];
      dir_d[n] = dir_q[n];
      cur      = {1'b0, pos_q[n]};
      if (tick) begin
        if (!mode[n]) begin
          pos_d[n] = tgt_q[n];
        end else if (dir_q[n]) begin
          if (cur + STEP_E >= POS_MAX_E) begin
            pos_d[n] = POS_W'(POS_MAX);
            dir_d[n] = 1'b0;
          end else begin
            pos_d[n] = POS_W'(cur + STEP_E);
          end
        end else begin
          if (cur <= STEP_E) begin
            pos_d[n] = '0;
            dir_d[n] = 1'b1;
          end else begin
            pos_d[n] = POS_W'(cur - STEP_E);
          end
        end
      end
    end
  end

  // pos_q only moves on the tick edge, so the width is stable for the whole frame.
  always_comb begin
    logic [31:0] width;
    width = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      width    = 32'(MIN_CYC) + 32'(pos_q[n]) * 32'(STEP_CYC);
      pwm_d[n] = (32'(cnt_q) < width);
    end
  end

  always_comb begin
    pos_out = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      pos_out[n*POS_W +: POS_W] = pos_q[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= '1;
      pwm_q <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        pos_q[n] <= '0;
        tgt_q[n] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      pwm_q <= pwm_d;
      for (int n = 0; n < CH_NUM; n++) begin
        pos_q[n] <= pos_d[n];
        tgt_q[n] <= tgt_d[n];
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Randomised scoreboard bench for servo_pwm_multi using a shortened frame so
// many frames, full sweep bounces and a mid-frame reset fit in a short run.
module tb_servo_pwm_multi;

  localparam int CLK_FRE    = 2;
  localparam int CH_NUM     = 4;
  localparam int PERIOD_US  = 100;
  localparam int MIN_US     = 10;
  localparam int MAX_US     = 80;
  localparam int POS_MAX    = 13;
  localparam int SWEEP_STEP = 2;
  localparam int POS_W      = $clog2(POS_MAX + 1);
  localparam int P          = PERIOD_US * CLK_FRE;
  localparam int MINC       = MIN_US * CLK_FRE;
  localparam int STEPC      = ((MAX_US - MIN_US) * CLK_FRE) / POS_MAX;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [CH_NUM-1:0]       mode = '0;
  logic                    cmd_valid = 1'b0;
  logic [3:0]              cmd_ch = '0;
  logic [POS_W-1:0]        cmd_pos = '0;
  logic                    cmd_ready;
  logic [CH_NUM-1:0]       pwm_out;
  logic [CH_NUM*POS_W-1:0] pos_out;
  logic                    frame_tick;

  servo_pwm_multi #(
    .CLK_FRE   (CLK_FRE),
    .CH_NUM    (CH_NUM),
    .PERIOD_US (PERIOD_US),
    .MIN_US    (MIN_US),
    .MAX_US    (MAX_US),
    .POS_MAX   (POS_MAX),
    .SWEEP_STEP(SWEEP_STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .cmd_valid (cmd_valid),
    .cmd_ch    (cmd_ch),
    .cmd_pos   (cmd_pos),
    .cmd_ready (cmd_ready),
    .pwm_out   (pwm_out),
    .pos_out   (pos_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_NUM-1:0][7:0]  pos;
    logic [CH_NUM-1:0][15:0] width;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic frame_t make_frame(input int p0, input int p1, input int p2, input int p3);
    frame_t f;
    int     p[4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int n = 0; n < CH_NUM; n++) begin
      f.pos[n]   = 8'(p[n]);
      f.width[n] = 16'(MINC + p[n] * STEPC);
    end
    return f;
  endfunction

  // Reference model: positions move only at the end of each P-cycle frame.
  int m_pos[CH_NUM];
  int m_tgt[CH_NUM];
  bit m_up[CH_NUM];
  int mcnt = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mcnt = 0;
      for (int n = 0; n < CH_NUM; n++) begin
        m_pos[n] = 0; m_tgt[n] = 0; m_up[n] = 1'b1;
      end
      exp_q.delete();
    end else begin
      if (mcnt == P - 1) begin
        for (int n = 0; n < CH_NUM; n++) begin
          if (!mode[n]) begin
            m_pos[n] = m_tgt[n];
          end else if (m_up[n]) begin
            m_pos[n] = (m_pos[n] + SWEEP_STEP > POS_MAX) ? POS_MAX : m_pos[n] + SWEEP_STEP;
            if (m_pos[n] == POS_MAX) m_up[n] = 1'b0;
          end else begin
            m_pos[n] = (m_pos[n] - SWEEP_STEP < 0) ? 0 : m_pos[n] - SWEEP_STEP;
            if (m_pos[n] == 0) m_up[n] = 1'b1;
          end
        end
        exp_q.push_back(make_frame(m_pos[0], m_pos[1], m_pos[2], m_pos[3]));
      end
      if (cmd_valid && int'(cmd_ch) < CH_NUM) begin
        m_tgt[cmd_ch] = (int'(cmd_pos) > POS_MAX) ? POS_MAX : int'(cmd_pos);
      end
      mcnt = (mcnt + 1) % P;
    end
  end

  // Monitor: frames delimited by frame_tick; expected frame popped at each frame start.
  initial begin
    frame_t cur;
    int     cyc;
    int     hi[CH_NUM];
    bit     started;
    bit     start_pending;
    cur = make_frame(0, 0, 0, 0);
    cyc = 0; started = 1'b0; start_pending = 1'b0;
    for (int n = 0; n < CH_NUM; n++) hi[n] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_pos", int'(pos_out), 0);
        chk("reset_ready", int'(cmd_ready), 0);
        chk("reset_tick", int'(frame_tick), 0);
        cur = make_frame(0, 0, 0, 0);
        cyc = 1; started = 1'b1; start_pending = 1'b0;
        for (int n = 0; n < CH_NUM; n++) hi[n] = 0;
      end else if (started) begin
        if (start_pending) begin
          if (exp_q.size() == 0) begin
            chk("frame_queue_empty", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            for (int n = 0; n < CH_NUM; n++)
              chk("pos_start", int'(pos_out[n*POS_W +: POS_W]), int'(cur.pos[n]));
          end
          start_pending = 1'b0;
          cyc = 0;
          for (int n = 0; n < CH_NUM; n++) hi[n] = 0;
        end
        cyc++;
        for (int n = 0; n < CH_NUM; n++) hi[n] += int'(pwm_out[n]);
        chk("cmd_ready", int'(cmd_ready), 1);
        if (frame_tick) begin
          chk("frame_len", cyc, P);
          for (int n = 0; n < CH_NUM; n++) begin
            chk("pwm_width", hi[n], int'(cur.width[n]));
            chk("pos_hold", int'(pos_out[n*POS_W +: POS_W]), int'(cur.pos[n]));
          end
          start_pending = 1'b1;
        end else if (cyc > P) begin
          chk("frame_tick_missing", cyc, P);
          cyc = 0;
          for (int n = 0; n < CH_NUM; n++) hi[n] = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int pos);
    cmd_valid = 1'b1;
    cmd_ch    = 4'(ch);
    cmd_pos   = POS_W'(pos);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_mcnt(input int target);
    int guard;
    guard = 0;
    while (mcnt != target && guard < 2 * P) begin
      step();
      guard++;
    end
    if (guard >= 2 * P) chk("wait_mcnt_timeout", guard, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b;
    repeat (3) step();
    rst = 1'b0;

    // Hold writes, clamp, discarded channels; ch3 sweeps from reset.
    mode = 4'b1000;
    write(1, 9);
    write(0, 15);
    write(7, 5);
    write(12, 3);
    repeat (3 * P) step();

    // Write landing in the frame_tick cycle.
    wait_mcnt(P - 1);
    write(2, 5);
    repeat (2 * P) step();

    // ch0 sweep -> hold with new target -> sweep again.
    mode[0] = 1'b1;
    repeat (4 * P) step();
    mode[0] = 1'b0;
    write(0, 3);
    repeat (2 * P) step();
    mode[0] = 1'b1;
    repeat (20 * P) step();

    // Randomised traffic.
    for (int i = 0; i < 40 * P; i++) begin
      cmd_valid = ($urandom_range(0, 15) == 0);
      cmd_ch    = 4'($urandom_range(0, 15));
      cmd_pos   = POS_W'($urandom_range(0, (1 << POS_W) - 1));
      if ($urandom_range(0, 299) == 0) begin
        b = $urandom_range(0, CH_NUM - 1);
        mode[b] = ~mode[b];
      end
      step();
    end
    cmd_valid = 1'b0;

    // Mid-frame asynchronous reset while ch1 is mid-pulse.
    mode = '0;
    write(1, 9);
    repeat (2 * P) step();
    wait_mcnt(80);
    chk("pre_reset_pwm1", int'(pwm_out[1]), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_pwm", int'(pwm_out), 0);
    chk("async_reset_ready", int'(cmd_ready), 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3 * P + 5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
